// File: rtl/sram_host_arbiter.sv
// -----------------------------------------------------------------------------
// sram_host_arbiter
//
// Connects NumHosts req/gnt/rvalid bus masters (host 0 = instruction fetch) to
// a single-port SRAM with byte enables. One host is granted per cycle; every
// grant is a complete transaction whose response appears exactly one cycle
// later on the shared read-data bus, steered to the granted host's rvalid.
// Accesses outside [MemStart, MemStart+MemSize) are granted but never reach
// the SRAM; they answer with err=1 and rdata=0.
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration with a
//                                         registered priority pointer
//                            undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   host_req_i  [N]     per-host request
//   host_we_i   [N]     per-host write enable
//   host_be_i   [4N]    per-host byte enables, host h on [4h+3:4h]
//   host_addr_i [32N]   per-host byte address
//   host_wdata_i[32N]   per-host write data
//   host_gnt_o  [N]     combinational grant, one-hot or zero
//   host_rvalid_o[N]    response valid, one-hot or zero
//   host_err_o  [N]     response error, qualified by rvalid
//   host_rdata_o[32]    shared read data, qualified by rvalid
//   mem_req_o/we_o/be_o/addr_o/wdata_o   SRAM command (addr is a word index)
//   mem_rdata_i[32]     SRAM read data, one cycle after mem_req_o
// -----------------------------------------------------------------------------
module sram_host_arbiter #(
   parameter int          NumHosts = 2,
   parameter int          MemSize  = 65536,
   parameter logic [31:0] MemStart = 32'h00000000,
   parameter int          IdxW     = $clog2(MemSize / 4)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumHosts-1:0]    host_req_i,
   input  logic [NumHosts-1:0]    host_we_i,
   input  logic [NumHosts*4-1:0]  host_be_i,
   input  logic [NumHosts*32-1:0] host_addr_i,
   input  logic [NumHosts*32-1:0] host_wdata_i,
   output logic [NumHosts-1:0]    host_gnt_o,
   output logic [NumHosts-1:0]    host_rvalid_o,
   output logic [NumHosts-1:0]    host_err_o,
   output logic [31:0]            host_rdata_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [3:0]             mem_be_o,
   output logic [IdxW-1:0]        mem_addr_o,
   output logic [31:0]            mem_wdata_o,
   input  logic [31:0]            mem_rdata_i
);

   localparam int          PtrW     = (NumHosts > 1) ? $clog2(NumHosts) : 1;
   localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);

   // ---------------------------------------------------------------------------
   // Winner selection
   // ---------------------------------------------------------------------------
   logic                w_found;
   logic [PtrW-1:0]     w_win;
   logic [NumHosts-1:0] w_sel;
   int                  w_scan_idx;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [PtrW-1:0]     r_ptr;
   logic [PtrW-1:0]     w_ptr_next;
`endif

   always_comb begin
      w_found    = 1'b0;
      w_win      = '0;
      w_sel      = '0;
      w_scan_idx = 0;
      for (int k = 0; k < NumHosts; k++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         // Scan starts at the pointer and wraps, so host r_ptr has top priority.
         w_scan_idx = int'(r_ptr) + k;
         if (w_scan_idx >= NumHosts) begin
            w_scan_idx = w_scan_idx - NumHosts;
         end
`else
         w_scan_idx = k;
`endif
         if (!w_found && host_req_i[w_scan_idx]) begin
            w_found           = 1'b1;
            w_win             = PtrW'(w_scan_idx);
            w_sel[w_scan_idx] = 1'b1;
         end
      end
   end

   // A grant is only valid outside reset; this also keeps the SRAM quiet.
   logic w_valid;
   assign w_valid = w_found && !rst_i;

   for (genvar gi = 0; gi < NumHosts; gi++) begin : g_gnt
      assign host_gnt_o[gi] = w_valid && w_sel[gi];
   end

   // ---------------------------------------------------------------------------
   // One-hot AND-OR mux of the winner's command
   // ---------------------------------------------------------------------------
   logic        w_we;
   logic [3:0]  w_be;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;

   always_comb begin
      w_we    = 1'b0;
      w_be    = '0;
      w_addr  = '0;
      w_wdata = '0;
      for (int k = 0; k < NumHosts; k++) begin
         if (w_sel[k]) begin
            w_we    = w_we    | host_we_i[k];
            w_be    = w_be    | host_be_i[4*k +: 4];
            w_addr  = w_addr  | host_addr_i[32*k +: 32];
            w_wdata = w_wdata | host_wdata_i[32*k +: 32];
         end
      end
   end

   logic w_in_range;
   logic w_mem_en;
   assign w_in_range = (w_addr & AddrMask) == MemStart;
   assign w_mem_en   = w_valid && w_in_range;

   // Byte offset within the word is irrelevant: the SRAM is word addressed.
   logic w_unused_addr;
   assign w_unused_addr = ^w_addr[1:0];

   // Idle and out-of-range cycles drive an all-zero command.
   assign mem_req_o   = w_mem_en;
   assign mem_we_o    = w_mem_en && w_we;
   assign mem_be_o    = w_mem_en ? w_be : 4'b0000;
   assign mem_addr_o  = w_mem_en ? w_addr[IdxW+1:2] : '0;
   assign mem_wdata_o = w_mem_en ? w_wdata : 32'h0;

   // ---------------------------------------------------------------------------
   // Round-robin pointer: moves just past the winner, holds on idle cycles
   // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   assign w_ptr_next = (w_win == PtrW'(NumHosts - 1)) ? '0 : w_win + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (w_valid) begin
         r_ptr <= w_ptr_next;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Response pipeline, loaded every cycle from the grant cycle
   // ---------------------------------------------------------------------------
   logic            r_resp_valid;
   logic [PtrW-1:0] r_resp_host;
   logic            r_resp_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_resp_valid <= 1'b0;
         r_resp_host  <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= w_valid;
         r_resp_host  <= w_win;
         r_resp_err   <= w_valid && !w_in_range;
      end
   end

   // Gating with rst_i drops a response whose delivery cycle coincides with
   // reset, so a transaction interrupted by reset never signals rvalid.
   logic w_resp_live;
   assign w_resp_live = r_resp_valid && !rst_i;

   for (genvar gi = 0; gi < NumHosts; gi++) begin : g_resp
      assign host_rvalid_o[gi] = w_resp_live && (r_resp_host == PtrW'(gi));
      assign host_err_o[gi]    = w_resp_live && (r_resp_host == PtrW'(gi)) && r_resp_err;
   end

   assign host_rdata_o = (w_resp_live && !r_resp_err) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_sram_host_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_host_arbiter
//
// Three-host bench for sram_host_arbiter. A simple SRAM model answers the
// memory port; an independent reference model (word array indexed by host
// byte address, arbitration by scanning requesters) predicts grants, SRAM
// commands and responses every cycle. Directed plan steps come first, then
// randomized traffic with occasional reset.
// -----------------------------------------------------------------------------
module tb_sram_host_arbiter;

   localparam int          NH        = 3;
   localparam int          MEM_SIZE  = 65536;
   localparam int          WORDS     = MEM_SIZE / 4;
   localparam int          IDXW      = 14;
   localparam logic [31:0] MEM_START = 32'h0;

   logic              clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_i;
   logic [NH-1:0]     host_req_i;
   logic [NH-1:0]     host_we_i;
   logic [NH*4-1:0]   host_be_i;
   logic [NH*32-1:0]  host_addr_i;
   logic [NH*32-1:0]  host_wdata_i;
   logic [NH-1:0]     host_gnt_o;
   logic [NH-1:0]     host_rvalid_o;
   logic [NH-1:0]     host_err_o;
   logic [31:0]       host_rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [3:0]        mem_be_o;
   logic [IDXW-1:0]   mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [31:0]       mem_rdata_i = 32'h0;

   sram_host_arbiter #(
      .NumHosts (NH),
      .MemSize  (MEM_SIZE),
      .MemStart (MEM_START)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .host_req_i    (host_req_i),
      .host_we_i     (host_we_i),
      .host_be_i     (host_be_i),
      .host_addr_i   (host_addr_i),
      .host_wdata_i  (host_wdata_i),
      .host_gnt_o    (host_gnt_o),
      .host_rvalid_o (host_rvalid_o),
      .host_err_o    (host_err_o),
      .host_rdata_o  (host_rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_be_o      (mem_be_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i)
   );

   // SRAM environment model: byte-enable writes, one-cycle read latency.
   logic [31:0] sram [WORDS] = '{default: 32'h0};
   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
         end else begin
            mem_rdata_i <= sram[mem_addr_o];
         end
      end
   end

   // Reference model state
   logic [31:0] ref_mem [WORDS] = '{default: 32'h0};
   int          m_ptr;
   bit          p_valid, p_err, p_read;
   int          p_host;
   logic [31:0] p_rdata;

   int n_checks;
   int n_errors;

   // Stimulus for the next cycle
   bit          t_rst;
   bit          t_req   [NH];
   bit          t_we    [NH];
   logic [3:0]  t_be    [NH];
   logic [31:0] t_addr  [NH];
   logic [31:0] t_wdata [NH];

   // Observations from the last step
   logic [NH-1:0] obs_gnt, obs_rv, obs_err;
   logic [31:0]   obs_rdata, obs_maddr;
   logic          obs_mreq;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_idle();
      t_rst = 1'b0;
      for (int h = 0; h < NH; h++) begin
         t_req[h] = 1'b0; t_we[h] = 1'b0; t_be[h] = 4'h0;
         t_addr[h] = 32'h0; t_wdata[h] = 32'h0;
      end
   endtask

   task automatic set_req(input int h, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
      t_req[h] = 1'b1; t_we[h] = we; t_be[h] = be; t_addr[h] = addr; t_wdata[h] = wdata;
   endtask

   // One clock cycle: apply stimulus, compare every output against the model.
   task automatic step();
      int            w, h, idx;
      bit            in_rng;
      logic [31:0]   a, e_rv, e_err;
      logic [NH-1:0] e_gnt;
      @(negedge clk);
      rst_i = t_rst;
      for (int k = 0; k < NH; k++) begin
         host_req_i[k]            = t_req[k];
         host_we_i[k]             = t_we[k];
         host_be_i[4*k +: 4]      = t_be[k];
         host_addr_i[32*k +: 32]  = t_addr[k];
         host_wdata_i[32*k +: 32] = t_wdata[k];
      end
      #1;
      // Response side: whatever was granted last cycle
      e_rv  = 32'h0;
      e_err = 32'h0;
      if (!t_rst && p_valid) begin
         e_rv = 32'h1 << p_host;
         if (p_err) e_err = e_rv;
      end
      check_eq("rvalid", 32'(host_rvalid_o), e_rv);
      check_eq("err", 32'(host_err_o), e_err);
      if (t_rst || !p_valid || p_err) check_eq("rdata_zero", host_rdata_o, 32'h0);
      else if (p_read)                check_eq("rdata", host_rdata_o, p_rdata);
      obs_rv = host_rvalid_o; obs_err = host_err_o; obs_rdata = host_rdata_o;

      // Arbitration
      w = -1;
      h = 0;
      if (!t_rst) begin
         for (int k = 0; k < NH; k++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            h = (m_ptr + k) % NH;
`else
            h = k;
`endif
            if (w < 0 && t_req[h]) w = h;
         end
      end
      e_gnt = '0;
      if (w >= 0) e_gnt[w] = 1'b1;
      check_eq("gnt", 32'(host_gnt_o), 32'(e_gnt));
      obs_gnt = host_gnt_o; obs_mreq = mem_req_o; obs_maddr = 32'(mem_addr_o);

      in_rng = 1'b0;
      idx    = 0;
      a      = 32'h0;
      if (w >= 0) begin
         a      = t_addr[w];
         in_rng = (a / MEM_SIZE) == (MEM_START / MEM_SIZE);
         idx    = int'((a - MEM_START) % MEM_SIZE) / 4;
      end
      check_eq("mem_req", 32'(mem_req_o), (w >= 0 && in_rng) ? 32'd1 : 32'd0);
      if (w >= 0 && in_rng) begin
         check_eq("mem_we", 32'(mem_we_o), t_we[w] ? 32'd1 : 32'd0);
         check_eq("mem_be", 32'(mem_be_o), 32'(t_be[w]));
         check_eq("mem_addr", 32'(mem_addr_o), 32'(idx));
         check_eq("mem_wdata", mem_wdata_o, t_wdata[w]);
      end else if (w < 0) begin
         check_eq("idle_we_be", {27'h0, mem_we_o, mem_be_o}, 32'h0);
         check_eq("idle_addr", 32'(mem_addr_o), 32'h0);
         check_eq("idle_wdata", mem_wdata_o, 32'h0);
      end

      // Advance the model
      if (t_rst) begin
         p_valid = 1'b0;
         m_ptr   = 0;
      end else begin
         p_valid = (w >= 0);
         if (w >= 0) begin
            p_host = w;
            p_err  = !in_rng;
            p_read = in_rng && !t_we[w];
            if (p_read) p_rdata = ref_mem[idx];
            if (in_rng && t_we[w]) begin
               for (int b = 0; b < 4; b++) begin
                  if (t_be[w][b]) ref_mem[idx][8*b +: 8] = t_wdata[w][8*b +: 8];
               end
            end
            m_ptr = (w + 1) % NH;
            $display("txn host=%0d %s addr=%h be=%b wdata=%h range=%0d",
                     w, t_we[w] ? "WR" : "RD", a, t_be[w], t_wdata[w], in_rng);
         end
      end
   endtask

   int          rr_gnt [6];
   int          exp_gnt [6];

   initial begin
      n_checks = 0; n_errors = 0; m_ptr = 0;
      p_valid = 1'b0; p_err = 1'b0; p_read = 1'b0; p_host = 0; p_rdata = 32'h0;
      rst_i = 1'b1; host_req_i = '0; host_we_i = '0; host_be_i = '0;
      host_addr_i = '0; host_wdata_i = '0;

      // Reset with all hosts requesting: nothing may be granted.
      set_idle(); t_rst = 1'b1;
      for (int h = 0; h < NH; h++) set_req(h, 1'b0, 4'hF, 32'h10, 32'h0);
      t_rst = 1'b1;
      step(); step();
      check_eq("rst_gnt", 32'(obs_gnt), 32'h0);

      // Host1 full-word write to 0x10
      set_idle(); set_req(1, 1'b1, 4'b1111, 32'h0000_0010, 32'hDEADBEEF); step();
      check_eq("plan_w_gnt", 32'(obs_gnt), 32'b010);
      check_eq("plan_w_idx", obs_maddr, 32'd4);
      // Host0 read of 0x10; host1 write response arrives now
      set_idle(); set_req(0, 1'b0, 4'b1111, 32'h0000_0010, 32'h0); step();
      check_eq("plan_w_rv", 32'(obs_rv), 32'b010);
      check_eq("plan_w_err", 32'(obs_err), 32'b000);
      // Host0 writes byte 1 only
      set_idle(); set_req(0, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000AA00); step();
      check_eq("plan_r_rv", 32'(obs_rv), 32'b001);
      check_eq("plan_r_data", obs_rdata, 32'hDEADBEEF);
      // Back-to-back reads: host0 then host1
      set_idle(); set_req(0, 1'b0, 4'b1111, 32'h0000_0010, 32'h0); step();
      set_idle(); set_req(1, 1'b0, 4'b1111, 32'h0000_0011, 32'h0); step();
      // Byte 1 (bits 15:8) of DEADBEEF replaced by AA
      check_eq("b2b_rv0", 32'(obs_rv), 32'b001);
      check_eq("b2b_data0", obs_rdata, 32'hDEADAAEF);
      // Host1 out-of-range read
      set_idle(); set_req(1, 1'b0, 4'b1111, 32'h0001_0000, 32'h0); step();
      check_eq("b2b_rv1", 32'(obs_rv), 32'b010);
      check_eq("b2b_data1", obs_rdata, 32'hDEADAAEF);
      check_eq("oor_mreq", 32'(obs_mreq), 32'd0);
      // Host2 read granted, then reset on the next edge
      set_idle(); set_req(2, 1'b0, 4'b1111, 32'h0000_0020, 32'h0); step();
      check_eq("oor_rv", 32'(obs_rv), 32'b010);
      check_eq("oor_err", 32'(obs_err), 32'b010);
      check_eq("oor_data", obs_rdata, 32'h0);
      set_idle(); t_rst = 1'b1; step();
      check_eq("rst_drop_rv", 32'(obs_rv), 32'h0);

      // Six cycles of full contention straight after reset
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_gnt = '{0, 1, 2, 0, 1, 2};
`else
      exp_gnt = '{0, 0, 0, 0, 0, 0};
`endif
      for (int c = 0; c < 6; c++) begin
         set_idle();
         for (int h = 0; h < NH; h++) set_req(h, 1'b0, 4'hF, 32'(4 * h), 32'h0);
         step();
         if (c == 0) check_eq("post_rst_rv", 32'(obs_rv), 32'h0);
         rr_gnt[c] = 0;
         for (int h = 0; h < NH; h++) if (obs_gnt[h]) rr_gnt[c] = h;
         check_eq($sformatf("contend_%0d", c), 32'(obs_gnt), 32'h1 << exp_gnt[c]);
      end

      // Randomized traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         set_idle();
         t_rst = ($urandom_range(0, 39) == 0);
         for (int h = 0; h < NH; h++) begin
            if ($urandom_range(0, 2) != 0) begin
               t_req[h]   = 1'b1;
               t_we[h]    = ($urandom_range(0, 1) == 1);
               t_be[h]    = 4'($urandom_range(0, 15));
               t_wdata[h] = $urandom();
               if ($urandom_range(0, 9) == 0)
                  t_addr[h] = {16'($urandom_range(1, 65535)), 16'($urandom())};
               else
                  t_addr[h] = 32'($urandom_range(0, 127));
            end
         end
         step();
      end

      // Drain the last response
      set_idle(); step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
